// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame width and state encodings for the 16-bit master and slave.
package spi_pkg;

  localparam int unsigned SPI_FRAME_BITS = 16;

  typedef enum logic [1:0] {
    WAIT_HI,
    IDLE,
    SHIFT
  } spi_slv_state_t;

  typedef enum logic [1:0] {
    M_IDLE,
    M_FRONT,
    M_XFER,
    M_BACK
  } spi_mst_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for an asynchronous input, with rise/fall detection on the synced level.
module spi_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI slave: oversampled SCLK/SS_n/MOSI, receives a command and returns tx_data in the same frame.
// Optional: define SPI_SLAVE_MISO_TRISTATE_EN to float MISO outside SHIFT and during reset.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FRAME_BITS  = SPI_FRAME_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SS_n,
  input  logic                  SCLK,
  input  logic                  MOSI,
  output logic                  MISO,
  input  logic [FRAME_BITS-1:0] tx_data,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_rdy,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int unsigned CW = $clog2(FRAME_BITS + 2);
  localparam int unsigned SW = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_BITS - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
  localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME_BITS + 1);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SYNC_STAGES);

  logic ss_sync, ss_rise, ss_fall;
  logic sclk_sync_unused, sclk_rise, sclk_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_sync;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk_i  (clk),
    .rst_i  (rst),
    .d_i    (SS_n),
    .sync_o (ss_sync),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
    .clk_i  (clk),
    .rst_i  (rst),
    .d_i    (SCLK),
    .sync_o (sclk_sync_unused),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) mosi_sync_q <= '0;
    else     mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
  end
  assign mosi_sync = mosi_sync_q[SYNC_STAGES-1];

  spi_slv_state_t        state_q, state_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [SW-1:0]         settle_q, settle_d;
  logic                  mosi_smpl_q, mosi_smpl_d;
  logic                  rx_rdy_q, rx_rdy_d;
  logic                  frame_err_q, frame_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_HI;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      cnt_q       <= '0;
      settle_q    <= '0;
      mosi_smpl_q <= 1'b0;
      rx_rdy_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      cnt_q       <= cnt_d;
      settle_q    <= settle_d;
      mosi_smpl_q <= mosi_smpl_d;
      rx_rdy_q    <= rx_rdy_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    cnt_d       = cnt_q;
    settle_d    = settle_q;
    mosi_smpl_d = mosi_smpl_q;
    rx_rdy_d    = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      WAIT_HI: begin
        // Synchronizers come out of reset preset high; trust ss_sync only once real samples reach it.
        if (settle_q != SETTLE_MAX) settle_d = settle_q + 1'b1;
        else if (ss_sync)           state_d  = IDLE;
      end
      IDLE: begin
        if (ss_fall) begin
          shreg_d = tx_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          if (cnt_q == CNT_FULL) begin
            rx_data_d = {shreg_q[FRAME_BITS-2:0], mosi_smpl_q};
            rx_rdy_d  = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = IDLE;
        end else if (sclk_rise) begin
          mosi_smpl_d = mosi_sync;
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
        end else if (sclk_fall && cnt_q != '0 && cnt_q <= CNT_LAST) begin
          shreg_d = {shreg_q[FRAME_BITS-2:0], mosi_smpl_q};
        end
      end
      default: state_d = WAIT_HI;
    endcase
  end

  assign rx_data   = rx_data_q;
  assign rx_rdy    = rx_rdy_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q == SHIFT);

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign MISO = (state_q == SHIFT && !rst) ? shreg_q[FRAME_BITS-1] : 1'bz;
`else
  assign MISO = (state_q == SHIFT) ? shreg_q[FRAME_BITS-1] : 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a bit-banged mode-0 master drives frames and checks both directions.
module tb_spi_slave;

  localparam int HALF = 8;
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  localparam logic MISO_IDLE = 1'bz;
`else
  localparam logic MISO_IDLE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, SS_n, SCLK, MOSI, MISO;
  logic [15:0] tx_data, rx_data;
  logic        rx_rdy, frame_err, busy;

  int n_vec = 0, n_err = 0;
  int rdy_cnt = 0, err_cnt = 0, both_cnt = 0;
  logic        mid_busy, rst_busy, rst_miso;
  logic [15:0] rst_rx;

  always #5 clk = ~clk;

  spi_slave #(.SYNC_STAGES(2), .FRAME_BITS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .SS_n      (SS_n),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .tx_data   (tx_data),
    .rx_data   (rx_data),
    .rx_rdy    (rx_rdy),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always @(negedge clk) begin
    if (rx_rdy === 1'b1) rdy_cnt++;
    if (frame_err === 1'b1) err_cnt++;
    if (rx_rdy === 1'b1 && frame_err === 1'b1) both_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // nbits rises are sent; rst_after>0 pulses reset right after that SCLK fall.
  task automatic spi_xfer(input logic [15:0] cmd, input int nbits, input int rst_after,
                          output logic [15:0] rd_o);
    rd_o = '0;
    SS_n = 1'b0;
    MOSI = cmd[15];
    tick(HALF);
    for (int k = 1; k <= nbits; k++) begin
      SCLK = 1'b1;
      rd_o = {rd_o[14:0], MISO};
      if (k == 4) mid_busy = busy;
      tick(HALF);
      SCLK = 1'b0;
      if (k < 16) MOSI = cmd[15-k];
      if (k == rst_after) begin
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        rst_busy = busy;
        rst_rx   = rx_data;
        rst_miso = MISO;
      end
      tick(HALF);
    end
    SS_n = 1'b1;
    tick(3 * HALF);
  endtask

  task automatic test_reset;
    rst = 1'b1; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0; tx_data = '0;
    tick(3);
    n_vec++; if (rx_data !== 16'h0000) begin n_err++; $display("FAIL reset_rx_data got %h exp %h", rx_data, 16'h0000); end
    n_vec++; if (rx_rdy !== 1'b0) begin n_err++; $display("FAIL reset_rx_rdy got %b exp 0", rx_rdy); end
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_vec++; if (MISO !== MISO_IDLE) begin n_err++; $display("FAIL reset_miso got %b exp %b", MISO, MISO_IDLE); end
    rst = 1'b0;
    tick(6);
  endtask

  task automatic test_basic;
    logic [15:0] rd;
    int r0, e0;
    r0 = rdy_cnt; e0 = err_cnt;
    tx_data = 16'h3C5A;
    spi_xfer(16'hA5C3, 16, 0, rd);
    n_vec++; if (rx_data !== 16'hA5C3) begin n_err++; $display("FAIL basic_rx_data got %h exp %h", rx_data, 16'hA5C3); end
    n_vec++; if (rd !== 16'h3C5A) begin n_err++; $display("FAIL basic_miso_word got %h exp %h", rd, 16'h3C5A); end
    n_vec++; if (rdy_cnt - r0 !== 1) begin n_err++; $display("FAIL basic_rdy_pulses got %0d exp 1", rdy_cnt - r0); end
    n_vec++; if (err_cnt - e0 !== 0) begin n_err++; $display("FAIL basic_err_pulses got %0d exp 0", err_cnt - e0); end
    n_vec++; if (mid_busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_mid got %b exp 1", mid_busy); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_after got %b exp 0", busy); end
    n_vec++; if (MISO !== MISO_IDLE) begin n_err++; $display("FAIL basic_miso_idle got %b exp %b", MISO, MISO_IDLE); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] rd;
    int r0;
    r0 = rdy_cnt;
    tx_data = 16'h3C5A;
    spi_xfer(16'h0001, 16, 0, rd);
    n_vec++; if (rx_data !== 16'h0001) begin n_err++; $display("FAIL b2b1_rx_data got %h exp %h", rx_data, 16'h0001); end
    n_vec++; if (rd !== 16'h3C5A) begin n_err++; $display("FAIL b2b1_miso_word got %h exp %h", rd, 16'h3C5A); end
    tx_data = 16'h8000;
    spi_xfer(16'hFFFE, 16, 0, rd);
    n_vec++; if (rx_data !== 16'hFFFE) begin n_err++; $display("FAIL b2b2_rx_data got %h exp %h", rx_data, 16'hFFFE); end
    n_vec++; if (rd !== 16'h8000) begin n_err++; $display("FAIL b2b2_miso_word got %h exp %h", rd, 16'h8000); end
    n_vec++; if (rdy_cnt - r0 !== 2) begin n_err++; $display("FAIL b2b_rdy_pulses got %0d exp 2", rdy_cnt - r0); end
  endtask

  task automatic test_short_frame;
    logic [15:0] rd;
    int r0, e0;
    r0 = rdy_cnt; e0 = err_cnt;
    spi_xfer(16'hA5A5, 8, 0, rd);
    n_vec++; if (err_cnt - e0 !== 1) begin n_err++; $display("FAIL short_err_pulses got %0d exp 1", err_cnt - e0); end
    n_vec++; if (rdy_cnt - r0 !== 0) begin n_err++; $display("FAIL short_rdy_pulses got %0d exp 0", rdy_cnt - r0); end
    n_vec++; if (rx_data !== 16'hFFFE) begin n_err++; $display("FAIL short_rx_hold got %h exp %h", rx_data, 16'hFFFE); end
  endtask

  task automatic test_reset_midframe;
    logic [15:0] rd;
    int r0, e0;
    r0 = rdy_cnt; e0 = err_cnt;
    spi_xfer(16'h5555, 16, 5, rd);
    n_vec++; if (rst_busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b exp 0", rst_busy); end
    n_vec++; if (rst_rx !== 16'h0000) begin n_err++; $display("FAIL midrst_rx_data got %h exp %h", rst_rx, 16'h0000); end
    n_vec++; if (rst_miso !== MISO_IDLE) begin n_err++; $display("FAIL midrst_miso got %b exp %b", rst_miso, MISO_IDLE); end
    n_vec++; if (rdy_cnt - r0 !== 0) begin n_err++; $display("FAIL midrst_rdy_pulses got %0d exp 0", rdy_cnt - r0); end
    n_vec++; if (err_cnt - e0 !== 0) begin n_err++; $display("FAIL midrst_err_pulses got %0d exp 0", err_cnt - e0); end
    n_vec++; if (rx_data !== 16'h0000) begin n_err++; $display("FAIL midrst_rx_after got %h exp %h", rx_data, 16'h0000); end
    tx_data = 16'h0F0F;
    spi_xfer(16'h1234, 16, 0, rd);
    n_vec++; if (rx_data !== 16'h1234) begin n_err++; $display("FAIL midrst_next_rx got %h exp %h", rx_data, 16'h1234); end
    n_vec++; if (rd !== 16'h0F0F) begin n_err++; $display("FAIL midrst_next_miso got %h exp %h", rd, 16'h0F0F); end
  endtask

  task automatic test_reset_held_low;
    logic [15:0] rd;
    int r0, e0;
    r0 = rdy_cnt; e0 = err_cnt;
    rst = 1'b1; SS_n = 1'b0;
    tick(4);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      SCLK = 1'b1; tick(HALF);
      SCLK = 1'b0; tick(HALF);
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL held_busy[%0d] got %b exp 0", i, busy); end
    end
    n_vec++; if (rdy_cnt - r0 !== 0 || err_cnt - e0 !== 0) begin
      n_err++; $display("FAIL held_pulses got rdy=%0d err=%0d exp 0/0", rdy_cnt - r0, err_cnt - e0);
    end
    SS_n = 1'b1;
    tick(10);
    tx_data = 16'h6A17;
    spi_xfer(16'hBEEF, 16, 0, rd);
    n_vec++; if (rx_data !== 16'hBEEF) begin n_err++; $display("FAIL held_next_rx got %h exp %h", rx_data, 16'hBEEF); end
    n_vec++; if (rd !== 16'h6A17) begin n_err++; $display("FAIL held_next_miso got %h exp %h", rd, 16'h6A17); end
  endtask

  task automatic test_no_overlap;
    n_vec++; if (both_cnt !== 0) begin n_err++; $display("FAIL rdy_err_overlap got %0d exp 0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_short_frame();
    test_reset_midframe();
    test_reset_held_low();
    test_no_overlap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- 16-bit SPI responder (mode 0: sample on SCLK rise, change on SCLK fall, MSB first). It is the far end of the team's 16-bit SPI master.
- Oversamples SCLK, SS_n and MOSI on the system clock. Receives a 16-bit command on MOSI and returns a preloaded 16-bit response on MISO in the same frame.
- Used by peripheral models and by on-chip register/sensor front ends that answer the master.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on SCLK/SS_n/MOSI (minimum 2).
- FRAME_BITS, 16, bits per frame; widths of tx_data/rx_data.

Ports:
- clk  input  1  system clock; SCLK period is at least 8 clk (the master gives 64).
- rst  input  1  synchronous, active-high reset.
- SS_n  input  1  active-low frame select from the master (asynchronous to clk).
- SCLK  input  1  serial clock from the master (asynchronous).
- MOSI  input  1  serial data from the master (asynchronous).
- MISO  output  1  serial response data.
- tx_data  input  FRAME_BITS  response word, captured at frame start.
- rx_data  output  FRAME_BITS  last valid received command.
- rx_rdy  output  1  one-clk pulse: rx_data was updated.
- frame_err  output  1  one-clk pulse: frame ended with a wrong bit count.
- busy  output  1  high while in SHIFT.

Behaviour:
- Reset (rst=1 at posedge clk) sets the state and outputs as follows:
  - State = WAIT_HI.
  - Synchronizers SS_n/SCLK preset to 1, MOSI to 0.
  - MISO=0, rx_data=0, rx_rdy=0, frame_err=0, busy=0, rise count=0.
- Edge detection: rise/fall/ss_fall/ss_rise come from the last synced sample versus one prior. Event-to-action latency is SYNC_STAGES+1 clk.
- State WAIT_HI: wait until synced SS_n==1, then go to IDLE. This prevents a false frame start when reset is released mid-frame.
- State IDLE, on ss_fall:
  - shift register <= tx_data; rise count <= 0; go to SHIFT.
  - tx_data is sampled only on that cycle.
- State SHIFT:
  - On rise: mosi_smpl <= synced MOSI; count <= count+1, saturating at FRAME_BITS+1.
  - On fall with 1 <= count <= FRAME_BITS-1: shift register <= {shreg[FRAME_BITS-2:0], mosi_smpl}.
  - A fall with count==0 is ignored (this is the master's front-porch edge). A fall with count>=FRAME_BITS is also ignored.
  - On ss_rise with count==FRAME_BITS: rx_data <= {shreg[FRAME_BITS-2:0], mosi_smpl}; rx_rdy pulses 1 clk.
  - On ss_rise with count!=FRAME_BITS: frame_err pulses 1 clk and rx_data holds.
  - Either way, go to IDLE.
- Rise and fall on the same clk cannot occur at the legal SCLK rate. If they do, rise is processed and fall is dropped.
- MISO = shreg[MSB] while in SHIFT, and 0 otherwise. The master's sample at rise k therefore sees tx_data bit (16-k).
- rx_rdy and frame_err are never asserted together. Both are 0 in every state except the ss_rise cycle.
- busy = (state==SHIFT).
- Reset mid-frame aborts silently: no rx_rdy and no frame_err. The block re-arms only after SS_n is seen high.

Optional Feature:
- Macro: SPI_SLAVE_MISO_TRISTATE_EN.
- Defined: MISO is driven 1'bz whenever the state is not SHIFT, and during reset. This allows a shared MISO line with several slaves.
- Undefined: MISO is driven 0 outside SHIFT, as stated above.

Decomposition:
- Package spi_pkg holds:
  - typedef enum logic [1:0] {WAIT_HI, IDLE, SHIFT} spi_slv_state_t;
  - localparam SPI_FRAME_BITS = 16.
  - The master's state typedef, so master and slave share frame-width constants.
- Sub-module spi_sync_edge: an N-stage synchronizer plus rise/fall detect. It is instantiated for SCLK and SS_n; MOSI uses its sync output only.

Test Plan:
- Master sends cmd 16'hA5C3 with tx_data=16'h3C5A:
  - Slave gives rx_data=16'hA5C3 with one rx_rdy pulse.
  - Master rd_data=16'h3C5A; frame_err stays 0.
- Two back-to-back frames:
  - Frame 1: cmd 16'h0001, then frame 2: cmd 16'hFFFE, with tx_data changed to 16'h8000 between the frames.
  - rx_data follows 16'h0001 then 16'hFFFE; master reads 16'h3C5A then 16'h8000.
- Short frame: SS_n is raised after 8 SCLK rises.
  - frame_err pulses once, rx_rdy=0, and rx_data keeps its previous value.
- Reset pulse after bit 5 of a frame:
  - All outputs are reset values, with no rx_rdy or frame_err pulse.
  - The remaining SCLKs of that frame are ignored. The next full frame, cmd 16'h1234, gives rx_data=16'h1234.
- Reset held while SS_n=0, then released:
  - The block stays in WAIT_HI with busy=0 until SS_n rises.
  - The following frame, cmd 16'hBEEF, is received correctly.
- Build with SPI_SLAVE_MISO_TRISTATE_EN:
  - MISO is z in IDLE/WAIT_HI and driven only during SHIFT.
  - Frame cmd 16'hA5C3 / tx_data 16'h3C5A still passes.
